// File: rtl/vagas_pkg.sv
// Shared types and constants for the parking-spot controller.
// The optional occupancy counter is enabled with OCUPACAO_CNT_EN.
package vagas_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ALOCA,
    ESPERA
  } estado_t;

  localparam int   NUM_VAGAS = 4;
  localparam int   IDX_W     = 2;
  localparam logic BLOCO_E   = 1'b0;
  localparam logic BLOCO_D   = 1'b1;

  function automatic logic [3:0] conta_bits(input logic [2*NUM_VAGAS-1:0] v);
    logic [3:0] cnt;
    cnt = '0;
    for (int i = 0; i < 2*NUM_VAGAS; i++) begin
      cnt = cnt + {3'b000, v[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/seletor_vaga.sv
// Combinational spot picker: preferred block first, falling back to the other,
// and the highest-index free spot within the chosen block.
module seletor_vaga
  import vagas_pkg::*;
(
  input  logic [NUM_VAGAS-1:0] ve,
  input  logic [NUM_VAGAS-1:0] vd,
  input  logic                 pref,
  output logic                 found,
  output logic                 bloco,
  output logic [IDX_W-1:0]     vaga
);

  logic [NUM_VAGAS-1:0] livre_pref;
  logic [NUM_VAGAS-1:0] livre_outro;
  logic [NUM_VAGAS-1:0] livre;

  always_comb begin
    livre_pref  = (pref == BLOCO_D) ? ~vd : ~ve;
    livre_outro = (pref == BLOCO_D) ? ~ve : ~vd;
    if (|livre_pref) begin
      bloco = pref;
      livre = livre_pref;
    end else begin
      bloco = ~pref;
      livre = livre_outro;
    end
    found = |livre;
    vaga  = '0;
    // Ascending scan so the last hit is the highest free index.
    for (int i = 0; i < NUM_VAGAS; i++) begin
      if (livre[i]) begin
        vaga = i[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/controle_vagas.sv
// Parking-lot controller: one allocation per entry request, exits free spots.
// Define OCUPACAO_CNT_EN to get a registered occupied-spot count on ocupacao.
module controle_vagas
  import vagas_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ent_req,
  input  logic                 P,
  input  logic                 sai_req,
  input  logic                 sai_bloco,
  input  logic [IDX_W-1:0]     sai_vaga,
  output logic [NUM_VAGAS-1:0] VE,
  output logic [NUM_VAGAS-1:0] VD,
  output logic                 ent_ok,
  output logic                 ent_neg,
  output logic                 ent_bloco,
  output logic [IDX_W-1:0]     ent_vaga,
  output logic                 cheio,
  output logic                 err,
  output logic [3:0]           ocupacao
);

  estado_t              estado, estado_nxt;
  logic                 pref_q;
  logic                 captura, concede, nega;
  logic                 sel_found, sel_bloco;
  logic [IDX_W-1:0]     sel_vaga;
  logic [NUM_VAGAS-1:0] ve_nxt, vd_nxt;
  logic                 err_nxt;

  seletor_vaga u_seletor (
    .ve    (VE),
    .vd    (VD),
    .pref  (pref_q),
    .found (sel_found),
    .bloco (sel_bloco),
    .vaga  (sel_vaga)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) estado <= IDLE;
    else        estado <= estado_nxt;
  end

  always_comb begin
    estado_nxt = estado;
    captura    = 1'b0;
    concede    = 1'b0;
    nega       = 1'b0;
    case (estado)
      IDLE: begin
        if (ent_req) begin
          captura    = 1'b1;
          estado_nxt = ALOCA;
        end
      end
      ALOCA: begin
        estado_nxt = ESPERA;
        if (sel_found) concede = 1'b1;
        else           nega    = 1'b1;
      end
      ESPERA: begin
        if (!ent_req) estado_nxt = IDLE;
      end
      default: estado_nxt = IDLE;
    endcase
  end

  // Exit clears first and allocation sets afterwards, so a grant wins a same-bit clash.
  always_comb begin
    ve_nxt  = VE;
    vd_nxt  = VD;
    err_nxt = 1'b0;
    if (sai_req) begin
      if (sai_bloco == BLOCO_D) begin
        err_nxt          = ~VD[sai_vaga];
        vd_nxt[sai_vaga] = 1'b0;
      end else begin
        err_nxt          = ~VE[sai_vaga];
        ve_nxt[sai_vaga] = 1'b0;
      end
    end
    if (concede) begin
      if (sel_bloco == BLOCO_D) vd_nxt[sel_vaga] = 1'b1;
      else                      ve_nxt[sel_vaga] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      VE        <= '0;
      VD        <= '0;
      ent_ok    <= 1'b0;
      ent_neg   <= 1'b0;
      err       <= 1'b0;
      ent_bloco <= 1'b0;
      ent_vaga  <= '0;
      pref_q    <= 1'b0;
    end else begin
      VE      <= ve_nxt;
      VD      <= vd_nxt;
      ent_ok  <= concede;
      ent_neg <= nega;
      err     <= err_nxt;
      if (concede) begin
        ent_bloco <= sel_bloco;
        ent_vaga  <= sel_vaga;
      end
      if (captura) pref_q <= P;
    end
  end

  assign cheio = (&VE) & (&VD);

`ifdef OCUPACAO_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) ocupacao <= '0;
    else        ocupacao <= conta_bits({vd_nxt, ve_nxt});
  end
`else
  assign ocupacao = '0;
`endif

endmodule
